// File: rtl/tw_sched_pkg.sv
// Shared types and width helpers for the tw_vgg frame scheduler.
package tw_sched_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      GAP    = 2'd2
   } state_t;

   // clog2 with a floor of one bit so degenerate parameters still give legal vectors
   function automatic int width_of(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int src_w(input int n_src);
      return width_of(n_src);
   endfunction

   function automatic int beat_w(input int frame_len);
      return width_of(frame_len);
   endfunction

   function automatic int out_w(input int out_per_frame);
      return width_of(out_per_frame);
   endfunction

   function automatic int occ_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/tw_sched_tag_fifo.sv
// Small synchronous FIFO holding the source ID of every frame admitted to the engine
// and not yet fully retired on the result side.
module tw_sched_tag_fifo
   import tw_sched_pkg::*;
#(
   parameter int TAG_W = 2,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [TAG_W-1:0] tag_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [TAG_W-1:0] head_o
);

   localparam int AW    = width_of(DEPTH);
   localparam int OCC_W = occ_w(DEPTH);

   logic [TAG_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [OCC_W-1:0] occ_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_i, pop_i})
            2'b10:   occ_q <= occ_q + 1'b1;
            2'b01:   occ_q <= occ_q - 1'b1;
            default: occ_q <= occ_q;
         endcase
      end
   end

   // Storage needs no reset: occupancy alone decides what is readable.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= tag_i;
   end

   assign full_o  = (occ_q == OCC_W'(DEPTH));
   assign empty_o = (occ_q == '0);
   assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/tw_vgg_frame_sched.sv
// Round-robin frame scheduler sharing one tw_vgg engine among N_SRC I/Q streams;
// tags each admitted frame so the engine's results come back labelled with their source.
module tw_vgg_frame_sched
   import tw_sched_pkg::*;
#(
   parameter int N_SRC         = 4,
   parameter int CH_IN         = 2,
   parameter int BW_IN         = 16,
   parameter int CH_OUT        = 24,
   parameter int BW_OUT        = 16,
   parameter int FRAME_LEN     = 1024,
   parameter int OUT_PER_FRAME = 8,
   parameter int MAX_INFLIGHT  = 4,
   parameter int GAP_CYCLES    = 2
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [N_SRC-1:0]                src_vld,
   input  logic [N_SRC*CH_IN*BW_IN-1:0]    src_data,
   output logic [N_SRC-1:0]                src_rdy,
   output logic                            eng_vld_in,
   output logic [CH_IN*BW_IN-1:0]          eng_data_in,
   input  logic                            eng_vld_out,
   input  logic [CH_OUT*BW_OUT-1:0]        eng_data_out,
   output logic                            res_vld,
   output logic [CH_OUT*BW_OUT-1:0]        res_data,
   output logic [src_w(N_SRC)-1:0]         res_src,
   output logic                            res_last,
   output logic                            busy,
   output logic                            err_orphan
);

   localparam int SRC_W  = src_w(N_SRC);
   localparam int BEAT_W = beat_w(FRAME_LEN);
   localparam int OUT_W  = out_w(OUT_PER_FRAME);
   localparam int GAP_W  = width_of(GAP_CYCLES);
   localparam int DIN_W  = CH_IN * BW_IN;
   localparam int DOUT_W = CH_OUT * BW_OUT;

   state_t             state_q, state_d;
   logic [SRC_W-1:0]   grant_q, grant_d;
   logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;
   logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
   logic [OUT_W-1:0]   out_cnt_q;

   logic               eng_vld_in_q;
   logic [DIN_W-1:0]   eng_data_in_q;
   logic               res_vld_q;
   logic [DOUT_W-1:0]  res_data_q;
   logic [SRC_W-1:0]   res_src_q;
   logic               res_last_q;
   logic               err_orphan_q;

   logic               pick_vld;
   logic [SRC_W-1:0]   pick_idx;
   logic [SRC_W-1:0]   cand;
   logic               beat;
   logic               push;
   logic               pop;
   logic               last_word;
   logic               fifo_full;
   logic               fifo_empty;
   logic [SRC_W-1:0]   fifo_head;
   logic [DIN_W-1:0]   src_lane [N_SRC];

   generate
      for (genvar gi = 0; gi < N_SRC; gi++) begin : g_lane
         assign src_lane[gi] = src_data[gi*DIN_W +: DIN_W];
      end
   endgenerate

   // Walk from the highest offset down so the source nearest rr_ptr wins.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      cand     = '0;
      for (int k = N_SRC - 1; k >= 0; k--) begin
         cand = SRC_W'((int'(rr_ptr_q) + k) % N_SRC);
         if (src_vld[cand]) begin
            pick_vld = 1'b1;
            pick_idx = cand;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
         gap_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      push       = 1'b0;
      src_rdy    = '0;
      beat       = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_vld && !fifo_full) begin
               grant_d    = pick_idx;
               rr_ptr_d   = (pick_idx == SRC_W'(N_SRC - 1)) ? '0 : pick_idx + 1'b1;
               beat_cnt_d = '0;
               push       = 1'b1;
               state_d    = STREAM;
            end
         end
         STREAM: begin
            // Ready depends only on the grant so sources may gate valid on it.
            src_rdy = N_SRC'(1) << grant_q;
            beat    = src_vld[grant_q];
            if (beat) begin
               if (beat_cnt_q == BEAT_W'(FRAME_LEN - 1)) begin
                  beat_cnt_d = '0;
                  if (GAP_CYCLES > 0) begin
                     state_d   = GAP;
                     gap_cnt_d = GAP_W'(GAP_CYCLES - 1);
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  beat_cnt_d = beat_cnt_q + 1'b1;
               end
            end
         end
         GAP: begin
            if (gap_cnt_q == '0) state_d = IDLE;
            else                 gap_cnt_d = gap_cnt_q - 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         eng_vld_in_q  <= 1'b0;
         eng_data_in_q <= '0;
      end else begin
         eng_vld_in_q <= beat;
         if (beat) eng_data_in_q <= src_lane[grant_q];
      end
   end

   assign last_word = (out_cnt_q == OUT_W'(OUT_PER_FRAME - 1));
   assign pop       = eng_vld_out && !fifo_empty && last_word;

   // A result with no tag outstanding is still forwarded, labelled source 0, and flagged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_vld_q    <= 1'b0;
         res_data_q   <= '0;
         res_src_q    <= '0;
         res_last_q   <= 1'b0;
         out_cnt_q    <= '0;
         err_orphan_q <= 1'b0;
      end else begin
         res_vld_q  <= eng_vld_out;
         res_last_q <= pop;
         if (eng_vld_out) begin
            res_data_q <= eng_data_out;
            if (fifo_empty) begin
               res_src_q    <= '0;
               err_orphan_q <= 1'b1;
            end else begin
               res_src_q <= fifo_head;
               out_cnt_q <= last_word ? '0 : out_cnt_q + 1'b1;
            end
         end
      end
   end

   tw_sched_tag_fifo #(
      .TAG_W (SRC_W),
      .DEPTH (MAX_INFLIGHT)
   ) u_tag_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .tag_i   (grant_d),
      .pop_i   (pop),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .head_o  (fifo_head)
   );

   assign eng_vld_in  = eng_vld_in_q;
   assign eng_data_in = eng_data_in_q;
   assign res_vld     = res_vld_q;
   assign res_data    = res_data_q;
   assign res_src     = res_src_q;
   assign res_last    = res_last_q;
   assign busy        = (state_q != IDLE) || !fifo_empty;
   assign err_orphan  = err_orphan_q;

endmodule

// File: tb/tb_tw_vgg_frame_sched.sv
// Directed bench for the frame scheduler: short frames, two-deep tag FIFO, two-cycle gap.
module tb_tw_vgg_frame_sched;

   localparam int NS  = 4;
   localparam int FL  = 16;
   localparam int OPF = 2;
   localparam int MI  = 2;
   localparam int GC  = 2;
   localparam int DW  = 32;
   localparam int RW  = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic [NS-1:0]   src_vld;
   logic [NS*DW-1:0] src_data;
   logic [NS-1:0]   src_rdy;
   logic            eng_vld_in;
   logic [DW-1:0]   eng_data_in;
   logic            eng_vld_out;
   logic [RW-1:0]   eng_data_out;
   logic            res_vld;
   logic [RW-1:0]   res_data;
   logic [1:0]      res_src;
   logic            res_last;
   logic            busy;
   logic            err_orphan;

   always #5 clk = ~clk;

   tw_vgg_frame_sched #(
      .N_SRC(NS), .CH_IN(2), .BW_IN(16), .CH_OUT(2), .BW_OUT(16),
      .FRAME_LEN(FL), .OUT_PER_FRAME(OPF), .MAX_INFLIGHT(MI), .GAP_CYCLES(GC)
   ) dut (
      .clk(clk), .rst(rst),
      .src_vld(src_vld), .src_data(src_data), .src_rdy(src_rdy),
      .eng_vld_in(eng_vld_in), .eng_data_in(eng_data_in),
      .eng_vld_out(eng_vld_out), .eng_data_out(eng_data_out),
      .res_vld(res_vld), .res_data(res_data), .res_src(res_src), .res_last(res_last),
      .busy(busy), .err_orphan(err_orphan)
   );

   typedef struct {
      logic [3:0]  vld;
      int          src;
      logic [31:0] dat;
      logic        evo;
      logic [31:0] eod;
      logic [3:0]  x_rdy;
      logic        x_evi;
      logic        x_ced;
      logic [31:0] x_ed;
      logic        x_rv;
      logic [1:0]  x_rs;
      logic        x_rl;
      logic [31:0] x_rd;
      logic        x_busy;
   } vec_t;

   vec_t tbl [64];
   int   n_tbl;
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Granted lane carries d, every other lane carries ~d so a wrong mux is visible.
   task automatic drive(input int src, input logic [31:0] d);
      for (int n = 0; n < NS; n++)
         src_data[n*DW +: DW] = (n == src) ? d : ~d;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      src_vld = '0;
      src_data = '0;
      eng_vld_out = 1'b0;
      eng_data_out = '0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic run_tbl(input string tag);
      for (int i = 0; i < n_tbl; i++) begin
         vec_t v;
         v = tbl[i];
         chk($sformatf("%s[%0d] src_rdy", tag, i), 64'(src_rdy), 64'(v.x_rdy));
         chk($sformatf("%s[%0d] eng_vld_in", tag, i), 64'(eng_vld_in), 64'(v.x_evi));
         if (v.x_ced)
            chk($sformatf("%s[%0d] eng_data_in", tag, i), 64'(eng_data_in), 64'(v.x_ed));
         chk($sformatf("%s[%0d] res_vld", tag, i), 64'(res_vld), 64'(v.x_rv));
         if (v.x_rv) begin
            chk($sformatf("%s[%0d] res_src", tag, i), 64'(res_src), 64'(v.x_rs));
            chk($sformatf("%s[%0d] res_last", tag, i), 64'(res_last), 64'(v.x_rl));
            chk($sformatf("%s[%0d] res_data", tag, i), 64'(res_data), 64'(v.x_rd));
         end
         chk($sformatf("%s[%0d] busy", tag, i), 64'(busy), 64'(v.x_busy));
         src_vld = v.vld;
         drive(v.src, v.dat);
         eng_vld_out = v.evo;
         eng_data_out = v.eod;
         step();
      end
   endtask

   // Waits for the next grant, checks which source got it, then checks the frame length.
   task automatic wait_grant(input logic [3:0] exp, input string nm);
      int n;
      n = 0;
      while (src_rdy == '0 && n < 100) begin step(); n++; end
      chk({nm, " grant"}, 64'(src_rdy), 64'(exp));
      n = 0;
      while (src_rdy != '0 && n < 100) begin step(); n++; end
      chk({nm, " frame cycles"}, 64'(n), 64'(FL));
   endtask

   task automatic send_results(input logic [1:0] src, input logic [31:0] base, input string nm);
      eng_vld_out = 1'b1;
      eng_data_out = base;
      step();
      chk({nm, " r0 vld"}, 64'(res_vld), 64'(1));
      chk({nm, " r0 src"}, 64'(res_src), 64'(src));
      chk({nm, " r0 last"}, 64'(res_last), 64'(0));
      chk({nm, " r0 data"}, 64'(res_data), 64'(base));
      eng_data_out = base + 32'd1;
      step();
      chk({nm, " r1 vld"}, 64'(res_vld), 64'(1));
      chk({nm, " r1 src"}, 64'(res_src), 64'(src));
      chk({nm, " r1 last"}, 64'(res_last), 64'(1));
      chk({nm, " r1 data"}, 64'(res_data), 64'(base + 32'd1));
      eng_vld_out = 1'b0;
      step();
      chk({nm, " idle vld"}, 64'(res_vld), 64'(0));
   endtask

   initial begin
      vec_t v;

      // Reset state
      rst = 1'b1;
      src_vld = '0;
      src_data = '0;
      eng_vld_out = 1'b0;
      eng_data_out = '0;
      step();
      chk("rst src_rdy", 64'(src_rdy), 64'(0));
      chk("rst eng_vld_in", 64'(eng_vld_in), 64'(0));
      chk("rst eng_data_in", 64'(eng_data_in), 64'(0));
      chk("rst res_vld", 64'(res_vld), 64'(0));
      chk("rst res_data", 64'(res_data), 64'(0));
      chk("rst res_src", 64'(res_src), 64'(0));
      chk("rst res_last", 64'(res_last), 64'(0));
      chk("rst busy", 64'(busy), 64'(0));
      chk("rst err_orphan", 64'(err_orphan), 64'(0));
      step();
      rst = 1'b0;

      // Single source 0, continuous valid, then two engine results
      n_tbl = 0;
      for (int s = 0; s <= 24; s++) begin
         v = '{default: '0};
         v.vld    = (s <= 16) ? 4'b0001 : 4'b0000;
         v.src    = 0;
         v.dat    = 32'(32'hA000 + s - 1);
         v.evo    = (s == 20 || s == 21);
         v.eod    = 32'(32'h5500 + s - 20);
         v.x_rdy  = (s >= 1 && s <= 16) ? 4'b0001 : 4'b0000;
         v.x_evi  = (s >= 2 && s <= 17);
         v.x_ced  = v.x_evi;
         v.x_ed   = 32'(32'hA000 + s - 2);
         v.x_rv   = (s == 21 || s == 22);
         v.x_rs   = 2'd0;
         v.x_rl   = (s == 22);
         v.x_rd   = 32'(32'h5500 + s - 21);
         v.x_busy = (s >= 1 && s <= 21);
         tbl[n_tbl] = v;
         n_tbl++;
      end
      run_tbl("t1");

      // Sources 1 and 3 always valid; FIFO depth 2 stalls the third frame
      do_reset();
      src_vld = 4'b1010;
      drive(1, 32'h1111);
      wait_grant(4'b0010, "t2 A");
      wait_grant(4'b1000, "t2 B");
      for (int k = 0; k < 6; k++) begin
         chk("t2 stall src_rdy", 64'(src_rdy), 64'(0));
         chk("t2 stall busy", 64'(busy), 64'(1));
         step();
      end
      eng_vld_out = 1'b1;
      eng_data_out = 32'h1100;
      step();
      chk("t2 A r0 src", 64'(res_src), 64'(1));
      chk("t2 A r0 last", 64'(res_last), 64'(0));
      chk("t2 A r0 src_rdy", 64'(src_rdy), 64'(0));
      eng_data_out = 32'h1101;
      step();
      chk("t2 A r1 src", 64'(res_src), 64'(1));
      chk("t2 A r1 last", 64'(res_last), 64'(1));
      chk("t2 A r1 data", 64'(res_data), 64'(32'h1101));
      chk("t2 still full src_rdy", 64'(src_rdy), 64'(0));
      eng_vld_out = 1'b0;
      step();
      chk("t2 admit after pop", 64'(src_rdy), 64'(4'b0010));
      wait_grant(4'b0010, "t2 C");
      send_results(2'd3, 32'h3300, "t2 B res");
      wait_grant(4'b1000, "t2 D");
      src_vld = 4'b0000;
      send_results(2'd1, 32'h1200, "t2 C res");
      send_results(2'd3, 32'h3400, "t2 D res");
      chk("t2 drained busy", 64'(busy), 64'(0));
      chk("t2 no orphan", 64'(err_orphan), 64'(0));

      // Orphan result with nothing admitted
      eng_vld_out = 1'b1;
      eng_data_out = 32'hDEAD0001;
      step();
      eng_vld_out = 1'b0;
      chk("orph res_vld", 64'(res_vld), 64'(1));
      chk("orph res_src", 64'(res_src), 64'(0));
      chk("orph res_last", 64'(res_last), 64'(0));
      chk("orph res_data", 64'(res_data), 64'(32'hDEAD0001));
      chk("orph err", 64'(err_orphan), 64'(1));
      for (int k = 0; k < 3; k++) begin
         step();
         chk("orph err sticky", 64'(err_orphan), 64'(1));
         chk("orph busy", 64'(busy), 64'(0));
      end
      rst = 1'b1;
      #1;
      chk("orph err cleared", 64'(err_orphan), 64'(0));
      step();
      rst = 1'b0;

      // Source 2 valid every other cycle, source 3 also requesting
      do_reset();
      n_tbl = 0;
      for (int s = 0; s <= 36; s++) begin
         int last_beat;
         v = '{default: '0};
         v.vld    = {1'(s <= 32), 1'((s % 2 == 0) && s <= 32), 2'b00};
         v.src    = 2;
         v.dat    = 32'(32'hC000 + s);
         v.x_rdy  = (s >= 1 && s <= 32) ? 4'b0100 : 4'b0000;
         v.x_evi  = (s % 2 == 1) && s >= 3 && s <= 33;
         v.x_ced  = (s >= 3);
         last_beat = (s % 2 == 1) ? s - 1 : s - 2;
         if (last_beat > 32) last_beat = 32;
         v.x_ed   = 32'(32'hC000 + last_beat);
         v.x_busy = (s >= 1);
         tbl[n_tbl] = v;
         n_tbl++;
      end
      run_tbl("t4");

      // Reset while beat 7 of a source-0 frame is on the bus
      do_reset();
      src_vld = 4'b0001;
      for (int s = 0; s < 8; s++) begin
         drive(0, 32'(32'hB000 + s));
         step();
      end
      chk("t5 pre src_rdy", 64'(src_rdy), 64'(4'b0001));
      chk("t5 pre eng_vld_in", 64'(eng_vld_in), 64'(1));
      chk("t5 pre eng_data_in", 64'(eng_data_in), 64'(32'hB007));
      rst = 1'b1;
      #1;
      chk("t5 async src_rdy", 64'(src_rdy), 64'(0));
      chk("t5 async eng_vld_in", 64'(eng_vld_in), 64'(0));
      chk("t5 async eng_data_in", 64'(eng_data_in), 64'(0));
      chk("t5 async busy", 64'(busy), 64'(0));
      src_vld = '0;
      step();
      step();
      rst = 1'b0;
      n_tbl = 0;
      for (int s = 0; s <= 18; s++) begin
         v = '{default: '0};
         v.vld    = 4'b0011;
         v.src    = 0;
         v.dat    = 32'(32'hE000 + s);
         v.x_rdy  = (s >= 1 && s <= 16) ? 4'b0001 : 4'b0000;
         v.x_evi  = (s >= 2 && s <= 17);
         v.x_ced  = v.x_evi;
         v.x_ed   = 32'(32'hE000 + s - 1);
         v.x_busy = (s >= 1);
         tbl[n_tbl] = v;
         n_tbl++;
      end
      run_tbl("t5");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: run did not complete by %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/tw_vgg_frame_sched.md
Name: tw_vgg_frame_sched

Overview:
- Frame-level scheduler that shares one tw_vgg inference engine among N_SRC independent I/Q sample streams.
- Grants the engine to one source for exactly one frame (FRAME_LEN samples), round-robin between sources.
- Records the owner of each admitted frame in a tag FIFO and labels engine results with that source ID.
- Sits between the radio front-end channel buffers and tw_vgg; result side feeds the classifier readout.

Parameters:
- N_SRC, 4, number of requesting streams (>=2).
- CH_IN, 2, channels per input sample (I,Q).
- BW_IN, 16, bits per input channel.
- CH_OUT, 24, channels per engine output word.
- BW_OUT, 16, bits per output channel.
- FRAME_LEN, 1024, input samples per frame.
- OUT_PER_FRAME, 8, engine output words produced per frame.
- MAX_INFLIGHT, 4, tag FIFO depth = max frames admitted but not fully retired (power of 2).
- GAP_CYCLES, 2, idle cycles forced between frames (0 allowed).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- src_vld  in  N_SRC  per-source sample valid.
- src_data  in  N_SRC*CH_IN*BW_IN  per-source sample, packed [N_SRC][CH_IN][BW_IN].
- src_rdy  out  N_SRC  per-source accept; a beat transfers when src_vld[i]&src_rdy[i].
- eng_vld_in  out  1  to tw_vgg vld_in.
- eng_data_in  out  CH_IN*BW_IN  to tw_vgg data_in.
- eng_vld_out  in  1  from tw_vgg vld_out.
- eng_data_out  in  CH_OUT*BW_OUT  from tw_vgg data_out.
- res_vld  out  1  result valid (no backpressure).
- res_data  out  CH_OUT*BW_OUT  result word.
- res_src  out  clog2(N_SRC)  owning source of res_data.
- res_last  out  1  last word of a frame's results.
- busy  out  1  state != IDLE or FIFO non-empty.
- err_orphan  out  1  sticky: eng_vld_out seen with tag FIFO empty.

Behaviour:
- Reset (async, rst=1): state=IDLE, rr_ptr=0, beat/gap/out counters=0, FIFO empty; src_rdy=0, eng_vld_in=0, eng_data_in=0, res_vld=0, res_data=0, res_src=0, res_last=0, busy=0, err_orphan=0. Reset mid-frame drops the partial frame and all tags; tw_vgg shares rst, so no stale results.
- FSM states: IDLE, STREAM, GAP.
- IDLE: if |src_vld and FIFO not full -> grant = first i with src_vld[i], searching from rr_ptr upward modulo N_SRC; push grant into FIFO; rr_ptr <= grant+1 mod N_SRC; beat_cnt=0; -> STREAM. FIFO full -> stay IDLE; all src_rdy=0.
- STREAM: src_rdy = one-hot(grant), combinational from state/grant only, never from src_vld. Each accepted beat increments beat_cnt. Source may drop src_vld mid-frame; no beat, no eng_vld_in pulse. On accepted beat with beat_cnt==FRAME_LEN-1 -> GAP (GAP_CYCLES>0, gap_cnt=GAP_CYCLES-1) else IDLE. src_rdy is low in the following cycle.
- GAP: src_rdy=0; gap_cnt counts down; at 0 -> IDLE.
- Engine input registered: eng_vld_in(t+1)=accepted beat(t); eng_data_in(t+1)=src_data[grant](t); eng_data_in holds when no beat. Latency 1 cycle.
- Result path registered, latency 1: res_vld(t+1)=eng_vld_out(t); res_data=eng_data_out; res_src=FIFO head; res_last=(out_cnt==OUT_PER_FRAME-1). On that word pop FIFO and set out_cnt=0, else out_cnt++.
- Orphan (eng_vld_out with FIFO empty): res_vld still asserted, res_src=0, res_last=0, no pop, err_orphan set until reset.
- Same-cycle FIFO push and pop: both take effect, occupancy unchanged; push when full is impossible by admission rule.
- Widths: beat_cnt clog2(FRAME_LEN); out_cnt clog2(OUT_PER_FRAME); FIFO occupancy clog2(MAX_INFLIGHT)+1.

Decomposition:
- Package tw_sched_pkg: state enum {IDLE,STREAM,GAP}; width helpers SRC_W=clog2(N_SRC), BEAT_W, OUT_W, OCC_W.
- Sub-module tw_sched_tag_fifo: synchronous FIFO of SRC_W-bit tags, depth MAX_INFLIGHT, push/pop/full/empty/head, async active-high rst.
- Round-robin pick and FSM stay in the top.

Test Plan:
- Single source 0, continuous valid, FRAME_LEN=16, OUT_PER_FRAME=2 -> 16 eng_vld_in pulses 1 cycle after accepts; data bit-exact; then GAP_CYCLES idle; 2 results with res_src=0 and res_last on the 2nd.
- Sources 1 and 3 always valid, rr_ptr=0 -> grant order 1,3,1,3; res_src sequence per frame 1,1,3,3,1,1.
- MAX_INFLIGHT=2, engine model withholding outputs -> third frame not admitted (src_rdy=0, state IDLE) until first frame's res_last pop; admitted the next cycle.
- Source 2 drops src_vld every other cycle -> frame takes 2*FRAME_LEN cycles; eng_vld_in pulses exactly FRAME_LEN; no other src_rdy asserted meanwhile.
- rst asserted at beat 7 of a frame -> outputs zero immediately (async); after release rr_ptr=0, FIFO empty, next frame starts at beat 0.
- eng_vld_out forced with no frame admitted -> res_vld=1, res_src=0, err_orphan=1 and stays set until rst.
